fifo_pop_stream: RTL and testbench
==================================

# fifo_pop_stream

Read-side adapter that drains a latency-L pop-interface memory FIFO (pop now, data appears READ_DATA_LATENCY cycles later, `may_pop` as its non-empty flag) and presents the words as a valid/ready stream. It sits between the platform FIFO's pop port and any consumer that applies backpressure. Pops are issued only when a slot is guaranteed in the internal skid buffer, so no word is ever dropped or duplicated.

## Interface
Parameters:
- WIDTH, 8, data word width in bits.
- READ_DATA_LATENCY, 2, cycles from `src_pop` high to the word on `src_pop_data`; must be at least 1.
- SKID_DEPTH, 3, skid buffer entries; elaboration error if below READ_DATA_LATENCY+1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- src_may_pop  in  1  source non-empty; already reflects every pop issued in earlier cycles.
- src_pop  out  1  pop request to source, at most one per cycle.
- src_pop_data  in  WIDTH  source data, valid READ_DATA_LATENCY cycles after the matching pop.
- out_valid  out  1  skid buffer holds a word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  WIDTH  head word of the skid buffer.

## Operation
- Reset values: src_pop=0, out_valid=0, out_data=0, in-flight pipe all 0, skid count 0, pointers 0.
- In-flight tracker: READ_DATA_LATENCY-bit shift register, input = src_pop. When the last tap is 1, capture src_pop_data into the skid buffer at that edge.
- inflight = popcount of the tracker; deq = out_valid & out_ready.
- src_pop = src_may_pop & (count + inflight - deq < SKID_DEPTH), combinational. The same-cycle dequeue frees a slot.
- Skid buffer: circular FIFO of SKID_DEPTH entries. Write pointer advances on capture. Read pointer advances on deq. Both wrap from SKID_DEPTH-1 to 0.
- count: width $clog2(SKID_DEPTH+1). count += capture - deq.
- Simultaneous capture and deq, including while full: count unchanged and both pointers advance.
- A capture into a full buffer with no deq is impossible by construction. The bench asserts it never happens.
- out_valid = (count != 0). out_data = mem[rd_ptr], registered storage with no combinational path from src_pop_data.
- Order is strictly preserved.
- Reset mid-operation: all in-flight and buffered words are discarded. The source must be reset in the same reset domain.

## Timing
- Pop at cycle t: data sampled at end of cycle t+L. out_valid is high from t+L+1. Minimum latency is L+1 cycles.
- With out_ready held high and src_may_pop high, throughput is one word per cycle, given SKID_DEPTH >= L+1.
- With out_ready low, src_pop stops once count + inflight reaches SKID_DEPTH. It resumes in the same cycle out_ready rises.
- out_valid, once high, stays high until deq. out_data stays stable while out_valid & !out_ready.
- src_pop never asserts while src_may_pop is low or while rst_n is low.

## Structure
- Shared package mem_stream_pkg: constant DEFAULT_READ_DATA_LATENCY = 2, shared with the memory wrappers. No typedefs needed.
- Local constants: count and pointer widths.
- One sub-module: pop_skid_buffer (WIDTH, DEPTH). It holds the circular storage, pointers and count, with ports wr_en/wr_data, rd_en, valid, rd_data and count.
- Top level keeps the in-flight tracker and the credit check.

## Test plan
All scenarios use L=2 and SKID_DEPTH=3.
- Reset: rst_n low mid-cycle -> src_pop=0, out_valid=0, out_data=0 immediately. They stay 0 for 3 cycles after release with src_may_pop=0.
- Single word: src_may_pop high for one cycle at t, source returns 0xA5 at t+2 -> src_pop high only at t, out_valid high at t+3 with out_data=0xA5, out_ready=1 -> out_valid low at t+4.
- Streaming: 16 words 0x00..0x0F, src_may_pop and out_ready held 1 -> src_pop high every cycle, out_valid continuous for 16 cycles, values in order.
- Backpressure: out_ready=0, src_may_pop=1 -> exactly 3 pops issued, count=3. out_data holds 0x00 stable. Then out_ready=1 -> 0x00, 0x01, 0x02… with no gap or loss.
- Random: random src_may_pop and out_ready over 2000 cycles, scoreboard against a source model -> no loss, duplication or reorder. Capture-while-full assertion never fires.
- Reset mid-flight: 2 words in flight and 1 buffered, rst_n pulsed low -> after release out_valid stays 0 and no stale word appears. The next popped word 0x5A is the first output.

Source files
------------

// File: rtl/mem_stream_pkg.sv
// Constants shared by the memory wrappers and the stream adapters built on them.
package mem_stream_pkg;

    localparam int DEFAULT_READ_DATA_LATENCY = 2;

    // Index width for a circular buffer; a single-entry buffer still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pop_skid_buffer.sv
// Circular skid buffer: registered storage, wrap-around pointers and an occupancy count.
module pop_skid_buffer
    import mem_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rd_go;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A read of an empty buffer is ignored so the pointer cannot run ahead.
    assign rd_go   = rd_en & valid;
    assign valid   = (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (rd_go) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (wr_en && !rd_go) begin
                count <= count + 1'b1;
            end else if (!wr_en && rd_go) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_pop_stream.sv
// Drains a fixed-latency pop-interface FIFO into a valid/ready stream without loss or duplication.
module fifo_pop_stream
    import mem_stream_pkg::*;
#(
    parameter int WIDTH             = 8,
    parameter int READ_DATA_LATENCY = DEFAULT_READ_DATA_LATENCY,
    parameter int SKID_DEPTH        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_may_pop,
    output logic             src_pop,
    input  logic [WIDTH-1:0] src_pop_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    if (READ_DATA_LATENCY < 1) begin : g_latency_check
        $error("fifo_pop_stream: READ_DATA_LATENCY must be at least 1");
    end
    if (SKID_DEPTH < READ_DATA_LATENCY + 1) begin : g_depth_check
        $error("fifo_pop_stream: SKID_DEPTH must be at least READ_DATA_LATENCY+1");
    end

    logic [READ_DATA_LATENCY-1:0] inflight_pipe;
    logic [CNT_W-1:0]             inflight;
    logic [CNT_W-1:0]             skid_count;
    logic [CNT_W:0]               committed;
    logic                         capture;
    logic                         deq;
    logic                         has_credit;

    assign capture = inflight_pipe[READ_DATA_LATENCY-1];
    assign deq     = out_valid & out_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_DATA_LATENCY; i++) begin
            inflight = inflight + CNT_W'(inflight_pipe[i]);
        end
    end

    // Every slot already owned (buffered or still in flight) must leave room for
    // this pop; a dequeue in the same cycle frees its slot immediately.
    assign committed  = {1'b0, skid_count} + {1'b0, inflight};
    assign has_credit = committed < ((CNT_W + 1)'(SKID_DEPTH) + (CNT_W + 1)'(deq));
    assign src_pop    = rst_n & src_may_pop & has_credit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_pipe <= '0;
        end else begin
            inflight_pipe[0] <= src_pop;
            for (int i = 1; i < READ_DATA_LATENCY; i++) begin
                inflight_pipe[i] <= inflight_pipe[i-1];
            end
        end
    end

    pop_skid_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (capture),
        .wr_data (src_pop_data),
        .rd_en   (deq),
        .valid   (out_valid),
        .rd_data (out_data),
        .count   (skid_count)
    );

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Bench for fifo_pop_stream: directed scenarios plus a randomized run against a queue-based reference.
module tb_fifo_pop_stream;

    localparam int W = 8;
    localparam int L = 2;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         src_may_pop = 1'b0;
    logic         src_pop;
    logic [W-1:0] src_pop_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;

    always #5 clk = ~clk;

    fifo_pop_stream #(
        .WIDTH             (W),
        .READ_DATA_LATENCY (L),
        .SKID_DEPTH        (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_may_pop  (src_may_pop),
        .src_pop      (src_pop),
        .src_pop_data (src_pop_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    // Reference: every popped word becomes visible L+1 cycles after its pop and
    // leaves in pop order; outstanding words never exceed D.
    typedef struct {
        logic [W-1:0] d;
        int           rdy;
    } ent_t;

    ent_t         mq[$];
    logic [W-1:0] src_q[$];
    logic [W-1:0] sched[int];

    int cyc      = 0;
    bit sb_en    = 0;
    bit rnd_mode = 0;
    bit want_may = 0;
    bit want_rdy = 0;
    int n_pops   = 0;
    int n_deqs   = 0;
    int n_tests  = 0;
    int n_fail   = 0;

    task automatic drive_loop();
        bit may;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (rnd_mode) begin
                may       = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                may       = want_may;
                out_ready = want_rdy;
            end
            src_may_pop = may && (src_q.size() != 0);
            if (sched.exists(cyc)) begin
                src_pop_data = sched[cyc];
                sched.delete(cyc);
            end else begin
                src_pop_data = W'($urandom);
            end
        end
    endtask

    task automatic scoreboard_loop();
        int           arrived;
        bit           exp_valid;
        bit           exp_pop;
        bit           deq;
        logic [W-1:0] w;
        forever begin
            @(negedge clk);
            if (sb_en && rst_n) begin
                arrived = 0;
                foreach (mq[i]) begin
                    if (mq[i].rdy <= cyc) arrived++;
                end
                exp_valid = (mq.size() > 0) && (mq[0].rdy <= cyc);
                n_tests++;
                if (out_valid !== exp_valid) begin
                    n_fail++;
                    $display("FAIL sb_valid cyc=%0d: got %b expected %b", cyc, out_valid, exp_valid);
                end
                if (exp_valid) begin
                    n_tests++;
                    if (out_data !== mq[0].d) begin
                        n_fail++;
                        $display("FAIL sb_data cyc=%0d: got %0h expected %0h", cyc, out_data, mq[0].d);
                    end
                end
                deq     = exp_valid && (out_ready === 1'b1);
                exp_pop = (src_may_pop === 1'b1) && ((mq.size() - int'(deq)) < D);
                n_tests++;
                if (src_pop !== exp_pop) begin
                    n_fail++;
                    $display("FAIL sb_pop cyc=%0d: got %b expected %b", cyc, src_pop, exp_pop);
                end
                n_tests++;
                if (arrived > D) begin
                    n_fail++;
                    $display("FAIL sb_capture_full cyc=%0d: got %0d buffered, limit %0d", cyc, arrived, D);
                end
                if (deq) begin
                    void'(mq.pop_front());
                    n_deqs++;
                end
                if (src_pop === 1'b1) begin
                    if (src_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_src_empty cyc=%0d: got pop with source empty, expected none", cyc);
                    end else begin
                        w = src_q.pop_front();
                        mq.push_back('{w, cyc + L + 1});
                        sched[cyc + L] = w;
                        n_pops++;
                    end
                end
            end
        end
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        sb_en    = 0;
        want_may = 0;
        src_q.delete();
        mq.delete();
        sched.delete();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        want_may = 0;
        want_rdy = 1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        int k;
        #1;
        n_tests++;
        if ({src_pop, out_valid, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_power_on: got pop=%b valid=%b data=%0h expected all 0", src_pop, out_valid, out_data);
        end
        release_reset();
        sb_en = 1;
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        want_rdy = 0;
        want_may = 1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        n_tests++;
        if (k == 20) begin
            n_fail++;
            $display("FAIL reset_fill_timeout: got no out_valid, expected one within 20 cycles");
        end
        assert_reset();
        src_q = '{8'h55};
        #1;
        n_tests++;
        if ({src_pop, out_valid, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_midcycle: got pop=%b valid=%b data=%0h expected all 0", src_pop, out_valid, out_data);
        end
        src_q.delete();
        release_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if ({src_pop, out_valid, out_data} !== '0) begin
                n_fail++;
                $display("FAIL reset_after_release: got pop=%b valid=%b data=%0h expected all 0", src_pop, out_valid, out_data);
            end
        end
        sb_en = 1;
    endtask

    task automatic test_single_word();
        int k;
        drain();
        want_rdy = 1;
        src_q = '{8'hA5};
        want_may = 1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (src_pop === 1'b1) break;
        end
        n_tests++;
        if (k == 20) begin
            n_fail++;
            $display("FAIL single_pop_timeout: got no pop, expected one within 20 cycles");
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_valid_t0: got %b expected 0", out_valid);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (src_pop !== 1'b0) begin
                n_fail++;
                $display("FAIL single_extra_pop t+%0d: got %b expected 0", c, src_pop);
            end
            n_tests++;
            if (out_valid !== (c == 3)) begin
                n_fail++;
                $display("FAIL single_valid t+%0d: got %b expected %b", c, out_valid, (c == 3));
            end
            if (c == 3) begin
                n_tests++;
                if (out_data !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL single_data: got %0h expected a5", out_data);
                end
            end
        end
        want_may = 0;
    endtask

    task automatic test_streaming();
        int k;
        drain();
        for (int i = 0; i < 16; i++) src_q.push_back(W'(i));
        want_rdy = 1;
        want_may = 1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (src_pop === 1'b1) break;
        end
        n_tests++;
        if (k == 20) begin
            n_fail++;
            $display("FAIL stream_pop_timeout: got no pop, expected one within 20 cycles");
        end
        for (int c = 0; c < 19; c++) begin
            if (c > 0) @(negedge clk);
            n_tests++;
            if (src_pop !== (c < 16)) begin
                n_fail++;
                $display("FAIL stream_pop c=%0d: got %b expected %b", c, src_pop, (c < 16));
            end
            if (c >= 3) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== W'(c - 3)) begin
                    n_fail++;
                    $display("FAIL stream_out c=%0d: got valid=%b data=%0h expected valid=1 data=%0h",
                             c, out_valid, out_data, c - 3);
                end
            end
        end
        want_may = 0;
    endtask

    task automatic test_backpressure();
        int pops;
        drain();
        for (int i = 0; i < 10; i++) src_q.push_back(W'(i));
        want_rdy = 0;
        want_may = 1;
        pops = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (src_pop === 1'b1) pops++;
            if (out_valid === 1'b1) begin
                n_tests++;
                if (out_data !== 8'h00) begin
                    n_fail++;
                    $display("FAIL bp_hold_data c=%0d: got %0h expected 0", c, out_data);
                end
            end
        end
        n_tests++;
        if (pops != D) begin
            n_fail++;
            $display("FAIL bp_pop_count: got %0d expected %0d", pops, D);
        end
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_valid_held: got %b expected 1", out_valid);
        end
        want_rdy = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== W'(i)) begin
                n_fail++;
                $display("FAIL bp_release i=%0d: got valid=%b data=%0h expected valid=1 data=%0h",
                         i, out_valid, out_data, i);
            end
        end
        want_may = 0;
    endtask

    task automatic test_random();
        int pops0;
        int deqs0;
        drain();
        pops0 = n_pops;
        deqs0 = n_deqs;
        for (int i = 0; i < 32; i++) src_q.push_back(W'($urandom));
        rnd_mode = 1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            if (src_q.size() < 8) begin
                for (int i = 0; i < 16; i++) src_q.push_back(W'($urandom));
            end
        end
        rnd_mode = 0;
        drain();
        n_tests++;
        if (mq.size() != 0) begin
            n_fail++;
            $display("FAIL rand_leftover: got %0d words undelivered expected 0", mq.size());
        end
        n_tests++;
        if ((n_deqs - deqs0) != (n_pops - pops0) || (n_pops - pops0) < 500) begin
            n_fail++;
            $display("FAIL rand_totals: got %0d delivered of %0d popped, expected equal and at least 500",
                     n_deqs - deqs0, n_pops - pops0);
        end
        src_q.delete();
    endtask

    task automatic test_reset_midflight();
        int k;
        int pops;
        drain();
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        want_rdy = 0;
        want_may = 1;
        pops = 0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (src_pop === 1'b1) pops++;
            if (out_valid === 1'b1) break;
        end
        n_tests++;
        if (k == 20 || pops != 3 || out_data !== 8'h01) begin
            n_fail++;
            $display("FAIL midflight_setup: got pops=%0d data=%0h expected pops=3 data=1", pops, out_data);
        end
        assert_reset();
        release_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midflight_stale c=%0d: got valid=%b data=%0h expected valid=0", c, out_valid, out_data);
            end
        end
        sb_en = 1;
        src_q = '{8'h5A};
        want_rdy = 1;
        want_may = 1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        n_tests++;
        if (k == 20 || out_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL midflight_first: got valid=%b data=%0h expected valid=1 data=5a", out_valid, out_data);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_extra: got valid=%b data=%0h expected valid=0", out_valid, out_data);
        end
        want_may = 0;
    endtask

    initial begin
        fork
            drive_loop();
            scoreboard_loop();
        join_none
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_random();
        test_reset_midflight();
        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
